deque_engine: RTL and testbench

- Hardware double-ended queue for WIDTH-bit words, stored in a DEPTH-entry circular buffer.
- Supports push_back, push_front, pop_back and pop_front, the same operations the testbench queues use.
- Sits downstream of the register/datapath stage: it buffers the words that stage produces and returns them to a consumer through a response channel with backpressure.
- Single clock; synchronous flush.

---
 rtl/deque_engine.sv | 134 +++++++++++++
 tb/tb_deque_engine.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/deque_engine.sv
// Double-ended queue over a circular buffer with a registered, backpressured response channel.
// One command per cycle; pops return data one edge after acceptance.
module deque_engine #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 8,
   localparam int unsigned AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_h,
   input  logic             flush,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_data,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_data,
   output logic             rsp_err,
   output logic [AW:0]      count,
   output logic             full,
   output logic             empty
);

   localparam logic [AW-1:0] PtrOne  = AW'(1);
   localparam logic [AW:0]   CntOne  = (AW+1)'(1);
   localparam logic [AW:0]   CntFull = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];

   logic [AW-1:0]    head_q, head_d, tail_q, tail_d;
   logic [AW:0]      count_q, count_d;
   logic             full_q, full_d, empty_q, empty_d;
   logic             rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
   logic [WIDTH-1:0] rsp_data_q, rsp_data_d;

   logic             accept, op_err, we;
   logic [AW-1:0]    wr_idx, rd_idx;

   assign cmd_ready = !flush && (!rsp_valid_q || rsp_ready);
   assign accept    = cmd_valid && cmd_ready;

   // cmd_op[1] selects pop; pops fail on empty, pushes fail on full.
   assign op_err = cmd_op[1] ? empty_q : full_q;
   assign rd_idx = cmd_op[0] ? head_q : tail_q - PtrOne;

   always_comb begin
      head_d      = head_q;
      tail_d      = tail_q;
      count_d     = count_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      rsp_err_d   = rsp_err_q;
      we          = 1'b0;
      wr_idx      = tail_q;
      if (flush) begin
         head_d      = '0;
         tail_d      = '0;
         count_d     = '0;
         rsp_valid_d = 1'b0;
         rsp_data_d  = '0;
         rsp_err_d   = 1'b0;
      end else if (accept) begin
         rsp_valid_d = 1'b1;
         rsp_err_d   = op_err;
         rsp_data_d  = '0;
         if (!op_err) begin
            unique case (cmd_op)
               2'b00: begin
                  we      = 1'b1;
                  wr_idx  = tail_q;
                  tail_d  = tail_q + PtrOne;
                  count_d = count_q + CntOne;
               end
               2'b01: begin
                  we      = 1'b1;
                  wr_idx  = head_q - PtrOne;
                  head_d  = head_q - PtrOne;
                  count_d = count_q + CntOne;
               end
               2'b10: begin
                  rsp_data_d = mem[rd_idx];
                  tail_d     = tail_q - PtrOne;
                  count_d    = count_q - CntOne;
               end
               2'b11: begin
                  rsp_data_d = mem[rd_idx];
                  head_d     = head_q + PtrOne;
                  count_d    = count_q - CntOne;
               end
               default: ;
            endcase
         end
      end else if (rsp_ready) begin
         rsp_valid_d = 1'b0;
      end
      full_d  = (count_d == CntFull);
      empty_d = (count_d == '0);
   end

   always_ff @(posedge clk) begin
      if (rst_h) begin
         head_q      <= '0;
         tail_q      <= '0;
         count_q     <= '0;
         full_q      <= 1'b0;
         empty_q     <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         head_q      <= head_d;
         tail_q      <= tail_d;
         count_q     <= count_d;
         full_q      <= full_d;
         empty_q     <= empty_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   // Storage has no reset; contents are meaningless once the pointers are cleared.
   always_ff @(posedge clk) begin
      if (we && !rst_h) mem[wr_idx] <= cmd_data;
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_err   = rsp_err_q;
   assign count     = count_q;
   assign full      = full_q;
   assign empty     = empty_q;

endmodule

// File: tb/tb_deque_engine.sv
// Directed self-checking bench for deque_engine (WIDTH=32, DEPTH=8).
module tb_deque_engine;

   localparam logic [1:0] PB = 2'b00, PF = 2'b01, QB = 2'b10, QF = 2'b11;

   logic        clk = 1'b0;
   logic        rst_h, flush, cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_err, full, empty;
   logic [1:0]  cmd_op;
   logic [31:0] cmd_data, rsp_data;
   logic [3:0]  count;

   int passed = 0;
   int total  = 0;

   deque_engine #(.WIDTH(32), .DEPTH(8)) dut (
      .clk(clk), .rst_h(rst_h), .flush(flush),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
      .count(count), .full(full), .empty(empty)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Drive one command for a single edge, then sample #1 after it.
   task automatic issue(input logic [1:0] op, input logic [31:0] data);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_data  = data;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      cmd_op    = 2'bxx;
      cmd_data  = 'x;
   endtask

   task automatic pop_chk(input string tag, input logic [1:0] op, input logic [31:0] exp_data,
                          input logic exp_err);
      issue(op, 32'h0);
      chk({tag, "_valid"}, {31'b0, rsp_valid}, 32'd1);
      chk({tag, "_data"}, rsp_data, exp_data);
      chk({tag, "_err"}, {31'b0, rsp_err}, {31'b0, exp_err});
   endtask

   task automatic do_reset();
      rst_h = 1'b1;
      @(posedge clk);
      #1;
      rst_h = 1'b0;
   endtask

   initial begin
      rst_h     = 1'b1;
      flush     = 1'b0;
      cmd_valid = 1'b0;
      cmd_op    = 2'b00;
      cmd_data  = '0;
      rsp_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst_h = 1'b0;

      chk("rst_count", {28'b0, count}, 32'd0);
      chk("rst_empty", {31'b0, empty}, 32'd1);
      chk("rst_full", {31'b0, full}, 32'd0);
      chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);

      // Mixed push/pop sequence
      issue(PB, 32'd0);
      chk("push_rsp_data", rsp_data, 32'd0);
      chk("push_rsp_err", {31'b0, rsp_err}, 32'd0);
      issue(PB, 32'd2);
      issue(PB, 32'd3);
      issue(PF, 32'd6);
      chk("seq_count4", {28'b0, count}, 32'd4);
      pop_chk("seq_popb", QB, 32'd3, 1'b0);
      issue(PB, 32'd8);
      pop_chk("seq_popf", QF, 32'd6, 1'b0);
      chk("seq_count3", {28'b0, count}, 32'd3);
      pop_chk("seq_f0", QF, 32'd0, 1'b0);
      pop_chk("seq_f1", QF, 32'd2, 1'b0);
      pop_chk("seq_f2", QF, 32'd8, 1'b0);
      chk("seq_empty", {31'b0, empty}, 32'd1);
      pop_chk("seq_under", QF, 32'd0, 1'b1);
      chk("seq_under_count", {28'b0, count}, 32'd0);

      // Fill to DEPTH and overflow
      do_reset();
      for (int i = 1; i <= 8; i++) issue(PB, 32'(i));
      chk("full_flag", {31'b0, full}, 32'd1);
      chk("full_count", {28'b0, count}, 32'd8);
      issue(PB, 32'd9);
      chk("over_err", {31'b0, rsp_err}, 32'd1);
      chk("over_data", rsp_data, 32'd0);
      chk("over_count", {28'b0, count}, 32'd8);
      for (int i = 1; i <= 8; i++) pop_chk("full_pop", QF, 32'(i), 1'b0);
      chk("full_drained", {31'b0, empty}, 32'd1);

      // Pointer wrap through index DEPTH-1
      do_reset();
      issue(PF, 32'hA);
      issue(PF, 32'hB);
      chk("wrap_mem7", dut.mem[7], 32'hA);
      chk("wrap_mem6", dut.mem[6], 32'hB);
      pop_chk("wrap_popb", QB, 32'hA, 1'b0);
      issue(PB, 32'hC);
      pop_chk("wrap_popf0", QF, 32'hB, 1'b0);
      pop_chk("wrap_popf1", QF, 32'hC, 1'b0);
      chk("wrap_empty", {31'b0, empty}, 32'd1);

      // Backpressure: response held, stalled command not accepted
      do_reset();
      issue(PB, 32'h11);
      issue(PB, 32'h22);
      issue(QF, 32'h0);
      rsp_ready = 1'b0;
      cmd_valid = 1'b1;
      cmd_op    = QB;
      cmd_data  = 32'h0;
      #1;
      chk("bp_ready_low", {31'b0, cmd_ready}, 32'd0);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         chk("bp_ready", {31'b0, cmd_ready}, 32'd0);
         chk("bp_valid", {31'b0, rsp_valid}, 32'd1);
         chk("bp_data", rsp_data, 32'h11);
         chk("bp_count", {28'b0, count}, 32'd1);
      end
      rsp_ready = 1'b1;
      #1;
      chk("bp_release_ready", {31'b0, cmd_ready}, 32'd1);
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      chk("bp_next_valid", {31'b0, rsp_valid}, 32'd1);
      chk("bp_next_data", rsp_data, 32'h22);
      chk("bp_next_count", {28'b0, count}, 32'd0);
      @(posedge clk);
      #1;
      chk("bp_drop_valid", {31'b0, rsp_valid}, 32'd0);

      // Flush with a response pending and a command offered
      do_reset();
      for (int i = 1; i <= 5; i++) issue(PB, 32'(i));
      rsp_ready = 1'b0;
      flush     = 1'b1;
      cmd_valid = 1'b1;
      cmd_op    = QF;
      cmd_data  = 32'h0;
      #1;
      chk("flush_ready", {31'b0, cmd_ready}, 32'd0);
      @(posedge clk);
      #1;
      flush     = 1'b0;
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      chk("flush_count", {28'b0, count}, 32'd0);
      chk("flush_empty", {31'b0, empty}, 32'd1);
      chk("flush_valid", {31'b0, rsp_valid}, 32'd0);
      pop_chk("flush_pop", QF, 32'd0, 1'b1);

      // Same, using reset instead of flush
      do_reset();
      for (int i = 1; i <= 5; i++) issue(PB, 32'(i + 16));
      rsp_ready = 1'b0;
      rst_h     = 1'b1;
      cmd_valid = 1'b1;
      cmd_op    = QF;
      @(posedge clk);
      #1;
      rst_h     = 1'b0;
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      chk("rst2_count", {28'b0, count}, 32'd0);
      chk("rst2_empty", {31'b0, empty}, 32'd1);
      chk("rst2_full", {31'b0, full}, 32'd0);
      chk("rst2_valid", {31'b0, rsp_valid}, 32'd0);
      chk("rst2_data", rsp_data, 32'd0);
      chk("rst2_err", {31'b0, rsp_err}, 32'd0);
      pop_chk("rst2_pop", QF, 32'd0, 1'b1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
